// File: rtl/alu_pkg.sv
// Shared opcode fields and FSM encoding for the bit-serial ALU controller.
package alu_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam int unsigned NEG_A = 3;
  localparam int unsigned NEG_B = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: optional operand inversion, then AND/OR/full-add.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       A,
  input  logic       B,
  input  logic       CarryIn,
  input  logic [3:0] Op,
  output logic       Result,
  output logic       CarryOut
);

  logic a_inv, b_inv;

  always_comb begin
    a_inv    = A ^ Op[NEG_A];
    b_inv    = B ^ Op[NEG_B];
    Result   = 1'b0;
    CarryOut = 1'b0;
    unique case (Op[1:0])
      OP_AND: Result = a_inv & b_inv;
      OP_OR:  Result = a_inv | b_inv;
      OP_ADD: begin
        Result   = a_inv ^ b_inv ^ CarryIn;
        CarryOut = (a_inv & b_inv) | (a_inv & CarryIn) | (b_inv & CarryIn);
      end
      default: begin
        Result   = 1'b0;
        CarryOut = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Sequences one 1-bit ALU slice over WIDTH cycles (LSB first) and assembles result and flags.
module bit_serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Err
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [3:0]         op_q, op_d;

  logic slice_res, slice_cout;
  logic is_add;

  assign is_add = (op_q[1:0] == OP_ADD);

  alu_bit_slice u_slice (
    .A        (a_sh_q[0]),
    .B        (b_sh_q[0]),
    .CarryIn  (carry_q),
    .Op       (op_q),
    .Result   (slice_res),
    .CarryOut (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    op_d    = op_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = A;
          b_sh_d  = B;
          op_d    = Op;
          cnt_d   = '0;
          // Two's-complement +1 is injected once here, never per bit.
          carry_d = Op[NEG_B];
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d  = {slice_res, res_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (is_add) carry_d = slice_cout;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          // Carry into the MSB is still in carry_q on the last bit.
          if (is_add) ovf_d = carry_q ^ slice_cout;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    Result    = res_q;
    Zero      = out_valid & ~|res_q;
    CarryOut  = out_valid & is_add & carry_q;
    Overflow  = out_valid & is_add & ovf_q;
    Err       = out_valid & (op_q[1:0] == OP_RSVD);
  end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Self-checking bench for bit_serial_alu_ctrl: vector table, random ops, scoreboard queue.
module tb_bit_serial_alu_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [W-1:0] A, B;
  logic [3:0]   Op;
  logic         out_valid, out_ready;
  logic [W-1:0] Result;
  logic         Zero, CarryOut, Overflow, Err;

  always #5 clk = ~clk;

  bit_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Op        (Op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Zero      (Zero),
    .CarryOut  (CarryOut),
    .Overflow  (Overflow),
    .Err       (Err)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
    logic         err;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    exp_t         e;
    int           hold;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] op);
    exp_t         e;
    logic [W-1:0] ai, bi;
    logic [W:0]   s;
    ai = op[3] ? ~a : a;
    bi = op[2] ? ~b : b;
    e  = '0;
    case (op[1:0])
      2'b00: e.res = ai & bi;
      2'b01: e.res = ai | bi;
      2'b10: begin
        s     = {1'b0, ai} + {1'b0, bi} + {{W{1'b0}}, op[2]};
        e.res = s[W-1:0];
        e.c   = s[W];
        e.v   = (ai[W-1] == bi[W-1]) && (s[W-1] != ai[W-1]);
      end
      default: e.err = 1'b1;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic idle_checks(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_err"}, 32'(Err), 32'd0);
    chk({tag, "_carry"}, 32'(CarryOut), 32'd0);
    chk({tag, "_ovf"}, 32'(Overflow), 32'd0);
  endtask

  // Accept one op; returns at a negedge right after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                       input exp_t e);
    int n;
    @(negedge clk);
    A = a; B = b; Op = op; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    sb_q.push_back(e);
    @(negedge clk);
    // Keep in_valid high with garbage inputs: must be ignored while busy.
    A = W'($urandom); B = W'($urandom); Op = 4'($urandom);
  endtask

  task automatic finish_op(input string tag, input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(W));
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; A = W'($urandom); B = W'($urandom); Op = 4'($urandom);
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_result"}, 32'(Result), 32'(e.res));
      chk({tag, "_hold_flags"}, {28'd0, Zero, CarryOut, Overflow, Err},
          {28'd0, e.z, e.c, e.v, e.err});
    end
    in_valid = 1'b0;
    chk({tag, "_result"}, 32'(Result), 32'(e.res));
    chk({tag, "_zero"}, 32'(Zero), 32'(e.z));
    chk({tag, "_carry"}, 32'(CarryOut), 32'(e.c));
    chk({tag, "_ovf"}, 32'(Overflow), 32'(e.v));
    chk({tag, "_err"}, 32'(Err), 32'(e.err));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    idle_checks({tag, "_after"});
  endtask

  vec_t vecs[7];

  initial begin
    exp_t e;
    logic [3:0] op;
    vecs[0] = '{a: 8'h5A, b: 8'h33, op: 4'b0010, e: '{8'h8D, 1'b0, 1'b0, 1'b1, 1'b0}, hold: 0};
    vecs[1] = '{a: 8'h10, b: 8'h10, op: 4'b0110, e: '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0}, hold: 0};
    vecs[2] = '{a: 8'h00, b: 8'h01, op: 4'b0110, e: '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0}, hold: 0};
    vecs[3] = '{a: 8'hF0, b: 8'h3C, op: 4'b0000, e: '{8'h30, 1'b0, 1'b0, 1'b0, 1'b0}, hold: 0};
    vecs[4] = '{a: 8'h0F, b: 8'hF0, op: 4'b1100, e: '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0}, hold: 0};
    vecs[5] = '{a: 8'h5A, b: 8'h33, op: 4'b0010, e: '{8'h8D, 1'b0, 1'b0, 1'b1, 1'b0}, hold: 5};
    vecs[6] = '{a: 8'hFF, b: 8'hFF, op: 4'b0011, e: '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1}, hold: 0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Op = '0;
    #12;
    idle_checks("reset");
    chk("reset_result", 32'(Result), 32'd0);
    chk("reset_zero", 32'(Zero), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].e);
      finish_op($sformatf("vec%0d", i), vecs[i].hold);
    end

    // Reset in the middle of an ADD that has a live carry chain.
    issue(8'hFF, 8'hFF, 4'b0010, model(8'hFF, 8'hFF, 4'b0010));
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    idle_checks("midreset");
    chk("midreset_result", 32'(Result), 32'd0);
    chk("midreset_zero", 32'(Zero), 32'd0);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    issue(8'h01, 8'h01, 4'b0010, '{8'h02, 1'b0, 1'b0, 1'b0, 1'b0});
    finish_op("post_reset_add", 0);

    for (int i = 0; i < 12; i++) begin
      A = W'($urandom); B = W'($urandom); op = 4'($urandom);
      e = model(A, B, op);
      issue(A, B, op, e);
      finish_op($sformatf("rand%0d", i), i % 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
